// File: rtl/wb_dec_pkg.sv
// Shared types and constants for the Wishbone slave-side decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wb_dec_pkg;

  // Upper bound on the number of slaves; address maps are sized to this.
  localparam int NS_MAX = 16;

  // Transfer supervisor states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERR    = 2'd2
  } state_e;

  // Fault cause encodings as reported on flt_cause_o.
  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_UNMAP = 2'd1;
  localparam logic [1:0] CAUSE_TMO   = 2'd2;
  localparam logic [1:0] CAUSE_SERR  = 2'd3;

  // One 32-bit base or mask per slave; entry k belongs to slave k.
  typedef logic [NS_MAX-1:0][31:0] map_t;

  // Default map: slave k owns the 256 MB window starting at k << 28.
  function automatic map_t def_base();
    map_t b;
    for (int k = 0; k < NS_MAX; k++) begin
      b[k] = 32'(k) << 28;
    end
    return b;
  endfunction

  localparam map_t DEF_BASE = def_base();
  localparam map_t DEF_MASK = {NS_MAX{32'hF000_0000}};

endpackage

// File: rtl/wb_dec_watchdog.sv
// Per-transfer cycle counter that flags when the slave has used up its budget.
// Latency: expired_o is a direct decode of the registered count.
// Backpressure: none; counts only while en_i is high and saturates at TIMEOUT.
module wb_dec_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_o = (cnt_q == CW'(TIMEOUT));

  // Next count: clear wins, otherwise step until the budget is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_slv_dec.sv
// Wishbone slave-side address decoder with watchdog and fault log.
// Latency: 1 cycle decode (strobe in IDLE reaches the slave next cycle); responses are combinational.
// Backpressure: the selected slave's ack/err/rty end the transfer; silence past TIMEOUT becomes a bus error.
module wb_slv_dec
  import wb_dec_pkg::*;
#(
  parameter int   NS      = 8,
  parameter int   AW      = 32,
  parameter int   DW      = 32,
  parameter int   TIMEOUT = 255,
  parameter map_t BASE    = DEF_BASE,
  parameter map_t MASK    = DEF_MASK
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [AW-1:0]    m_adr_i,
  input  logic             m_cyc_i,
  input  logic             m_stb_i,
  output logic [DW-1:0]    m_dat_o,
  output logic             m_ack_o,
  output logic             m_err_o,
  output logic             m_rty_o,
  output logic [NS-1:0]    s_cyc_o,
  output logic [NS-1:0]    s_stb_o,
  input  logic [NS*DW-1:0] s_dat_i,
  input  logic [NS-1:0]    s_ack_i,
  input  logic [NS-1:0]    s_err_i,
  input  logic [NS-1:0]    s_rty_i,
  output logic             flt_o,
  output logic [1:0]       flt_cause_o,
  output logic [AW-1:0]    flt_adr_o
);

  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  state_e        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          flt_q;
  logic [1:0]    cause_q;
  logic [AW-1:0] fadr_q;

  logic          hit;
  logic [SW-1:0] hit_idx;
  logic          sel_ack, sel_err, sel_rty, sel_term;
  logic          wd_clr, wd_en, wd_expired;
  logic          log_vld;
  logic [1:0]    log_cause;
  logic [AW-1:0] log_adr;

  // Address map lookup; scanning downwards lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      if ((m_adr_i & AW'(MASK[k])) == AW'(BASE[k])) begin
        hit     = 1'b1;
        hit_idx = SW'(k);
      end
    end
  end

  assign sel_ack  = s_ack_i[sel_q];
  assign sel_err  = s_err_i[sel_q];
  assign sel_rty  = s_rty_i[sel_q];
  assign sel_term = sel_ack | sel_err | sel_rty;

  // The count is only meaningful while ACTIVE, so it is held at zero otherwise.
  assign wd_clr = (state_q != ACTIVE);
  assign wd_en  = (state_q == ACTIVE) && m_cyc_i && !sel_term;

  wb_dec_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  // FSM next state and fault capture; abort beats termination beats timeout.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    log_vld   = 1'b0;
    log_cause = CAUSE_NONE;
    log_adr   = adr_q;
    case (state_q)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          sel_d = hit_idx;
          adr_d = m_adr_i;
          if (hit) begin
            state_d = ACTIVE;
          end else begin
            state_d   = ERR;
            log_vld   = 1'b1;
            log_cause = CAUSE_UNMAP;
            log_adr   = m_adr_i;
          end
        end
      end
      ACTIVE: begin
        if (!m_cyc_i) begin
          state_d = IDLE;
        end else if (sel_term) begin
          state_d = IDLE;
          if (sel_err) begin
            log_vld   = 1'b1;
            log_cause = CAUSE_SERR;
          end
        end else if (wd_expired) begin
          state_d   = ERR;
          log_vld   = 1'b1;
          log_cause = CAUSE_TMO;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Transfer state, latched selection and address.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
    end
  end

  // Fault log written on the logging edge; the pulse marks the first cycle it is visible.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      flt_q   <= 1'b0;
      cause_q <= CAUSE_NONE;
      fadr_q  <= '0;
    end else begin
      flt_q <= log_vld;
      if (log_vld) begin
        cause_q <= log_cause;
        fadr_q  <= log_adr;
      end
    end
  end

  assign flt_o       = flt_q;
  assign flt_cause_o = cause_q;
  assign flt_adr_o   = fadr_q;

  // Slave drive and response routing; strobes are gated by cycle so an abort drops them at once.
  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    m_dat_o = '0;
    m_ack_o = 1'b0;
    m_err_o = 1'b0;
    m_rty_o = 1'b0;
    if (state_q == ACTIVE) begin
      m_dat_o = s_dat_i[int'(sel_q) * DW +: DW];
      if (m_cyc_i) begin
        s_cyc_o[sel_q] = 1'b1;
        s_stb_o[sel_q] = m_stb_i;
        m_ack_o        = sel_ack;
        m_err_o        = sel_err;
        m_rty_o        = sel_rty;
      end
    end else if (state_q == ERR) begin
      m_err_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_slv_dec.sv
// Directed bench for wb_slv_dec: decode, unmapped, timeout, slave error, abort, reset.
// Latency: inputs driven 1 ns after the clock edge, outputs checked 1 ns later.
// Backpressure: the bench plays the slaves directly, cycle by cycle.
module tb_wb_slv_dec;
  import wb_dec_pkg::*;

  localparam int NS = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  function automatic map_t mk_mask();
    map_t m;
    m    = DEF_MASK;
    m[7] = 32'h0;
    return m;
  endfunction

  localparam map_t TB_MASK = mk_mask();

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [AW-1:0]    m_adr_i;
  logic             m_cyc_i, m_stb_i;
  logic [DW-1:0]    m_dat_o;
  logic             m_ack_o, m_err_o, m_rty_o;
  logic [NS-1:0]    s_cyc_o, s_stb_o;
  logic [NS*DW-1:0] s_dat_i;
  logic [NS-1:0]    s_ack_i, s_err_i, s_rty_i;
  logic             flt_o;
  logic [1:0]       flt_cause_o;
  logic [AW-1:0]    flt_adr_o;

  int n_cmp = 0;
  int n_mis = 0;
  int flt_cnt = 0;

  wb_slv_dec #(
    .NS(NS), .AW(AW), .DW(DW), .TIMEOUT(TO), .BASE(DEF_BASE), .MASK(TB_MASK)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_adr_i(m_adr_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .flt_o(flt_o), .flt_cause_o(flt_cause_o), .flt_adr_o(flt_adr_o)
  );

  always #5 clk_i = ~clk_i;

  // Count fault pulses, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (flt_o) flt_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mst(input logic cyc, input logic stb, input logic [AW-1:0] adr);
    m_cyc_i = cyc;
    m_stb_i = stb;
    m_adr_i = adr;
  endtask

  task automatic slv_clr();
    s_dat_i = '0;
    s_ack_i = '0;
    s_err_i = '0;
    s_rty_i = '0;
  endtask

  initial begin
    rst_i = 1'b0;
    mst(1'b0, 1'b0, '0);
    slv_clr();
    #2;
    chk("rst_stb", s_stb_o, 0);
    chk("rst_cyc", s_cyc_o, 0);
    chk("rst_mresp", {m_ack_o, m_err_o, m_rty_o}, 0);
    chk("rst_dat", m_dat_o, 0);
    chk("rst_flt", {flt_o, flt_cause_o}, 0);
    chk("rst_fadr", flt_adr_o, 0);
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b1;

    // Zero-wait read from slave 3.
    step(); mst(1'b1, 1'b1, 32'h3000_0010); #1;
    chk("t1_c0_stb", s_stb_o, 0);
    step(); s_dat_i[3*DW +: DW] = 32'hDEAD_BEEF; s_ack_i[3] = 1'b1; #1;
    chk("t1_c1_stb", s_stb_o, 8'h08);
    chk("t1_c1_cyc", s_cyc_o, 8'h08);
    chk("t1_c1_ack", m_ack_o, 1);
    chk("t1_c1_err", m_err_o, 0);
    chk("t1_c1_dat", m_dat_o, 32'hDEAD_BEEF);
    step(); mst(1'b0, 1'b0, '0); slv_clr(); #1;
    chk("t1_c2_stb", s_stb_o, 0);
    chk("t1_c2_dat", m_dat_o, 0);
    chk("t1_nofault", {flt_cause_o, 32'(flt_cnt)}, 0);

    // Unmapped: 0xF0000000 (beyond NS) and 0x70000000 (slave 7 masked out).
    step(); mst(1'b1, 1'b1, 32'hF000_0000); #1;
    chk("t2a_c0_stb", s_stb_o, 0);
    step(); #1;
    chk("t2a_c1_err", m_err_o, 1);
    chk("t2a_c1_stb", s_stb_o, 0);
    chk("t2a_c1_flt", flt_o, 1);
    chk("t2a_cause", flt_cause_o, CAUSE_UNMAP);
    chk("t2a_adr", flt_adr_o, 32'hF000_0000);
    step(); mst(1'b0, 1'b0, '0); #1;
    chk("t2a_c2_err", m_err_o, 0);
    step(); mst(1'b1, 1'b1, 32'h7000_0000); #1;
    chk("t2b_c0_stb", s_stb_o, 0);
    step(); #1;
    chk("t2b_c1_stb", s_stb_o, 0);
    chk("t2b_c1_err", m_err_o, 1);
    chk("t2b_adr", flt_adr_o, 32'h7000_0000);
    step(); mst(1'b0, 1'b0, '0); #1;

    // Timeout on silent slave 2.
    step(); mst(1'b1, 1'b1, 32'h2000_0000); #1;
    for (int c = 1; c <= TO + 1; c++) begin
      step(); #1;
      chk($sformatf("t3_c%0d_stb", c), s_stb_o, 8'h04);
      chk($sformatf("t3_c%0d_err", c), m_err_o, 0);
    end
    step(); #1;
    chk("t3_c6_err", m_err_o, 1);
    chk("t3_c6_stb", s_stb_o, 0);
    chk("t3_c6_flt", flt_o, 1);
    chk("t3_cause", flt_cause_o, CAUSE_TMO);
    chk("t3_adr", flt_adr_o, 32'h2000_0000);
    step(); mst(1'b0, 1'b0, '0); #1;
    chk("t3_fltcnt", flt_cnt, 3);

    // Slave 5: ack and err together after three wait cycles.
    step(); mst(1'b1, 1'b1, 32'h5000_0004); #1;
    for (int c = 1; c <= 3; c++) begin
      step(); #1;
      chk($sformatf("t4_c%0d_stb", c), s_stb_o, 8'h20);
      chk($sformatf("t4_c%0d_ack", c), m_ack_o, 0);
    end
    step(); s_ack_i[5] = 1'b1; s_err_i[5] = 1'b1; #1;
    chk("t4_c4_ack", m_ack_o, 1);
    chk("t4_c4_err", m_err_o, 1);
    step(); mst(1'b1, 1'b0, 32'h5000_0004); slv_clr(); #1;
    chk("t4_c5_idle", s_cyc_o, 0);
    chk("t4_c5_flt", flt_o, 1);
    chk("t4_cause", flt_cause_o, CAUSE_SERR);
    chk("t4_adr", flt_adr_o, 32'h5000_0004);
    step(); mst(1'b0, 1'b0, '0); #1;

    // Abort in the second ACTIVE cycle to slave 1.
    step(); mst(1'b1, 1'b1, 32'h1000_0000); #1;
    step(); #1;
    chk("t5_c1_stb", s_stb_o, 8'h02);
    step(); m_cyc_i = 1'b0; #1;
    chk("t5_c2_stb", s_stb_o, 0);
    chk("t5_c2_cyc", s_cyc_o, 0);
    chk("t5_c2_mresp", {m_ack_o, m_err_o, m_rty_o}, 0);
    step(); mst(1'b1, 1'b0, 32'h1000_0000); #1;
    chk("t5_c3_idle", s_cyc_o, 0);
    chk("t5_cause", flt_cause_o, CAUSE_SERR);
    chk("t5_adr", flt_adr_o, 32'h5000_0004);
    step(); mst(1'b0, 1'b0, '0); #1;
    chk("t5_fltcnt", flt_cnt, 4);

    // Reset mid-ACTIVE to slave 4, then a normal transfer to slave 0.
    step(); mst(1'b1, 1'b1, 32'h4000_0000); #1;
    step(); #1;
    chk("t6_c1_stb", s_stb_o, 8'h10);
    rst_i = 1'b0; #1;
    chk("t6_rst_stb", s_stb_o, 0);
    chk("t6_rst_cyc", s_cyc_o, 0);
    chk("t6_rst_mresp", {m_ack_o, m_err_o, m_rty_o}, 0);
    chk("t6_rst_log", {flt_cause_o, flt_adr_o}, 0);
    mst(1'b0, 1'b0, '0);
    #1 rst_i = 1'b1;
    step(); mst(1'b1, 1'b1, 32'h0000_0100); #1;
    step(); s_dat_i[0 +: DW] = 32'h1234_5678; s_ack_i[0] = 1'b1; #1;
    chk("t6_c1_stb", s_stb_o, 8'h01);
    chk("t6_c1_ack", m_ack_o, 1);
    chk("t6_c1_dat", m_dat_o, 32'h1234_5678);
    step(); mst(1'b0, 1'b0, '0); slv_clr(); #1;
    chk("t6_c2_stb", s_stb_o, 0);
    chk("t6_c2_cause", flt_cause_o, CAUSE_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/wb_slv_dec.md
# wb_slv_dec

Slave-side Wishbone address decoder and transfer supervisor; the counterpart of the round-robin master arbiter. It takes the single granted master's request, registers the decode to one of `NS` slaves, and routes that slave's read data and termination back to the master. A per-transfer watchdog converts unmapped addresses and non-responding slaves into a one-cycle bus error, and logs the faulting address for software.

## Interface
- `NS`, 8: number of slaves, 1..16.
- `AW`, 32: address width.
- `DW`, 32: data width.
- `TIMEOUT`, 255: maximum ACTIVE cycles without termination, ≥1.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: asynchronous, active-low reset.
- `m_adr_i` in AW: master address.
- `m_cyc_i` in 1: master cycle.
- `m_stb_i` in 1: master strobe.
- `m_dat_o` out DW: read data muxed from the selected slave.
- `m_ack_o` out 1: acknowledge to the master.
- `m_err_o` out 1: error to the master.
- `m_rty_o` out 1: retry to the master.
- `s_cyc_o` out NS: one-hot slave cycle.
- `s_stb_o` out NS: one-hot slave strobe.
- `s_dat_i` in NS*DW: slave read data, slave k at `[k*DW +: DW]`.
- `s_ack_i` in NS: slave acknowledges.
- `s_err_i` in NS: slave errors.
- `s_rty_i` in NS: slave retries.
- `flt_o` out 1: one-cycle pulse when a fault is logged.
- `flt_cause_o` out 2: last fault cause; 0 none, 1 unmapped, 2 timeout, 3 slave error.
- `flt_adr_o` out AW: address of the last fault.

## Operation
- Address map: slave k hits when `(m_adr_i & MASK[k]) == BASE[k]`. The lowest index wins. No hit means unmapped.
- **IDLE**
  - All `s_cyc_o`/`s_stb_o` are 0.
  - On `m_cyc_i & m_stb_i`: latch `sel_q` = hit index, `adr_q` = `m_adr_i`, and clear the counter.
  - Go to ACTIVE on a hit, or to ERR on unmapped.
- **ACTIVE**
  - Slave drive: `s_cyc_o[sel_q]` = `m_cyc_i` and `s_stb_o[sel_q]` = `m_stb_i`.
  - Master routing: `m_dat_o` = `s_dat_i[sel_q]`; `m_ack_o`, `m_err_o`, `m_rty_o` follow the selected slave, combinationally.
  - Any termination (ack, err or rty) → IDLE. A slave error also logs cause 3.
  - `m_cyc_i` low → IDLE (abort). No response to the master, no fault logged.
  - No termination and counter == `TIMEOUT` → ERR with cause 2. Otherwise the counter increments.
- **ERR**
  - One cycle: `m_err_o` = 1 and all slave strobes 0.
  - Cause 1 or 2 logged; `flt_adr_o` = `adr_q`, and `flt_o` pulses this cycle.
  - Next state is IDLE.
- Simultaneous events:
  - Priority within ACTIVE: abort > termination > timeout.
  - Ack and err in the same cycle: both are passed through, and cause 3 is logged.
- Fault log: `flt_cause_o`/`flt_adr_o` hold until the next fault; the newest fault overwrites.
- `m_dat_o` is 0 outside ACTIVE.

## Timing
- Decode latency is 1 cycle: a strobe seen in IDLE at cycle 0 reaches the slave at cycle 1.
- Zero-wait slave: ack at cycle 1; IDLE at cycle 2.
- Back-to-back transfers cost 2 cycles each. Cycle N+1 is spent in IDLE, and a strobe still high there is decoded as a new transfer.
- Timeout: ACTIVE runs for cycles 1..`TIMEOUT`+1 with counter values 0..`TIMEOUT`; `m_err_o` is asserted at cycle `TIMEOUT`+2.
- Unmapped: `m_err_o` at cycle 1.
- Reset (asynchronous assert, synchronous release):
  - State IDLE, counter 0, all outputs 0, `flt_cause_o`=0, `flt_adr_o`=0.
  - A mid-transfer reset drops slave strobes immediately.
- Counter width is `$clog2(TIMEOUT+1)`. It never wraps, because reaching `TIMEOUT` forces ERR.

## Structure
- Package `wb_dec_pkg`:
  - State enum `{IDLE, ACTIVE, ERR}`.
  - Cause encodings as constants.
  - `NS`-entry `BASE`/`MASK` arrays; the default is slave k at `0x{k}0000000` with mask `0xF0000000`.
- Sub-module `wb_dec_watchdog`: the counter, holding clear/enable inputs and a `expired` output.
- The top holds the FSM, the decode and the muxes.

## Test plan
- Read of `0x30000010`, slave 3 acks at its first strobe cycle with data `0xDEADBEEF` → `s_stb_o`=`0x08` at cycle 1, `m_ack_o`=1 and `m_dat_o`=`0xDEADBEEF` at cycle 1, no fault.
- With `MASK[7]`=0, access `0xF0000000` → `m_err_o` at cycle 1, `flt_cause_o`=1, `flt_adr_o`=`0xF0000000`, and no slave strobe at any point.
- `TIMEOUT`=4, slave 2 silent → strobe held for cycles 1–5, `m_err_o` at cycle 6, cause 2, `flt_o` pulses once.
- Slave 5 asserts `s_err_i` and `s_ack_i` together after 3 waits → both passed through, cause 3, return to IDLE the next cycle.
- Drop `m_cyc_i` in the second ACTIVE cycle → strobes go to 0 that cycle, IDLE next, and the fault log is unchanged.
- Assert `rst_i`=0 mid-ACTIVE → all `s_*_o`/`m_*_o` read 0 before the next clock edge; after release, a normal transfer to slave 0 completes.
